// File: rtl/q2_panel_ctrl.sv
// Front-panel controller for the q2 core: synchronizes and debounces switches and buttons,
// then turns accepted presses into one-cycle command pulses with lockout, priority and auto-repeat.
module q2_panel_ctrl #(
  parameter int WIDTH        = 12,
  parameter int DEBOUNCE     = 16,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = 1024,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     sw_raw,
  input  logic                 incp_raw,
  input  logic                 dep_raw,
  input  logic                 start_raw,
  input  logic                 stop_raw,
  input  logic                 run,
  output logic [WIDTH-1:0]     sw,
  output logic                 incp,
  output logic                 dep,
  output logic                 start,
  output logic                 stop,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] run_cycles
);

  localparam int DB_W    = $clog2(DEBOUNCE + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX + 1) : 1;
  localparam bit REP_EN  = (REPEAT_DELAY > 0);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
  localparam logic [REP_W-1:0] DELAY_M1 = REP_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [REP_W-1:0] RATE_M1  = REP_W'(REPEAT_RATE - 1);

  // Button bit order everywhere: [0]=incp [1]=dep [2]=start [3]=stop
  logic [3:0] btn_raw;
  assign btn_raw = {stop_raw, start_raw, dep_raw, incp_raw};

  logic [3:0]             bs1_q, bs1_d, bs2_q, bs2_d;
  logic [3:0]             stable_q, stable_d, prev_q, prev_d, armed_q, armed_d;
  logic [3:0][DB_W-1:0]   bcnt_q, bcnt_d;
  logic [1:0]             valid_q, valid_d;
  logic [WIDTH-1:0]       ss1_q, ss1_d, ss2_q, ss2_d;
  logic [WIDTH-1:0]       sw_q, sw_d, sw_cand_q, sw_cand_d;
  logic [DB_W-1:0]        sw_cnt_q, sw_cnt_d;
  logic                   rep_on_q, rep_on_d, rep_rate_q, rep_rate_d;
  logic [REP_W-1:0]       rep_cnt_q, rep_cnt_d;
  logic [3:0]             pulse_q, pulse_d;
  logic                   run_q, run_d, run_prev_q, run_prev_d, halted_q, halted_d;
  logic [CNT_WIDTH-1:0]   run_cycles_q, run_cycles_d;

  logic [3:0]             cand;
  logic [REP_W-1:0]       rep_target;
  logic                   rep_fire;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
    bs1_d        = btn_raw;
    bs2_d        = bs1_q;
    ss1_d        = sw_raw;
    ss2_d        = ss1_q;
    stable_d     = stable_q;
    bcnt_d       = bcnt_q;
    prev_d       = stable_q;
    valid_d      = {valid_q[0], 1'b1};
    sw_d         = sw_q;
    sw_cand_d    = sw_cand_q;
    sw_cnt_d     = sw_cnt_q;
    rep_on_d     = 1'b0;
    rep_rate_d   = 1'b0;
    rep_cnt_d    = '0;
    pulse_d      = '0;
    run_d        = run;
    run_prev_d   = run_q;
    halted_d     = run_prev_q & ~run_q;
    run_cycles_d = run_cycles_q;

    for (int b = 0; b < 4; b++) begin
      if (bs2_q[b] == stable_q[b]) begin
        bcnt_d[b] = '0;
      end else if (bcnt_q[b] == DB_LAST) begin
        stable_d[b] = bs2_q[b];
        bcnt_d[b]   = '0;
      end else begin
        bcnt_d[b] = bcnt_q[b] + 1'b1;
      end
    end

    // Arm only once the synchronizers hold real post-reset samples showing the button released.
    armed_d = armed_q | ({4{valid_q[1]}} & ~bs2_q & ~stable_q);

    if (ss2_q != sw_cand_q) begin
      sw_cand_d = ss2_q;
      sw_cnt_d  = '0;
    end else if (sw_cand_q == sw_q) begin
      sw_cnt_d = '0;
    end else if (sw_cnt_q == DB_LAST) begin
      sw_d     = sw_cand_q;
      sw_cnt_d = '0;
    end else begin
      sw_cnt_d = sw_cnt_q + 1'b1;
    end

    rep_target = rep_rate_q ? RATE_M1 : DELAY_M1;
    rep_fire   = REP_EN && rep_on_q && stable_q[0] && !run && (rep_cnt_q == rep_target);

    cand    = armed_q & stable_q & ~prev_q;
    cand[0] = cand[0] | rep_fire;
    if (run) cand[2:0] = 3'b000;

    if      (cand[3]) pulse_d = 4'b1000;
    else if (cand[2]) pulse_d = 4'b0100;
    else if (cand[1]) pulse_d = 4'b0010;
    else if (cand[0]) pulse_d = 4'b0001;

    // The repeat timer restarts from every issued incp pulse; first target is the delay, then the rate.
    if (pulse_d[0]) begin
      rep_on_d   = REP_EN;
      rep_rate_d = rep_fire;
    end else if (rep_on_q && stable_q[0] && !run && !(|pulse_d[3:1])) begin
      rep_on_d   = 1'b1;
      rep_rate_d = rep_rate_q;
      rep_cnt_d  = rep_cnt_q + 1'b1;
    end

    if (pulse_d[2]) begin
      run_cycles_d = '0;
    end else if (run && (run_cycles_q != {CNT_WIDTH{1'b1}})) begin
      run_cycles_d = run_cycles_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      bs1_q        <= '0;
      bs2_q        <= '0;
      ss1_q        <= '0;
      ss2_q        <= '0;
      stable_q     <= '0;
      bcnt_q       <= '0;
      prev_q       <= '0;
      armed_q      <= '0;
      valid_q      <= '0;
      sw_q         <= '0;
      sw_cand_q    <= '0;
      sw_cnt_q     <= '0;
      rep_on_q     <= 1'b0;
      rep_rate_q   <= 1'b0;
      rep_cnt_q    <= '0;
      pulse_q      <= '0;
      run_q        <= 1'b0;
      run_prev_q   <= 1'b0;
      halted_q     <= 1'b0;
      run_cycles_q <= '0;
    end else begin
      bs1_q        <= bs1_d;
      bs2_q        <= bs2_d;
      ss1_q        <= ss1_d;
      ss2_q        <= ss2_d;
      stable_q     <= stable_d;
      bcnt_q       <= bcnt_d;
      prev_q       <= prev_d;
      armed_q      <= armed_d;
      valid_q      <= valid_d;
      sw_q         <= sw_d;
      sw_cand_q    <= sw_cand_d;
      sw_cnt_q     <= sw_cnt_d;
      rep_on_q     <= rep_on_d;
      rep_rate_q   <= rep_rate_d;
      rep_cnt_q    <= rep_cnt_d;
      pulse_q      <= pulse_d;
      run_q        <= run_d;
      run_prev_q   <= run_prev_d;
      halted_q     <= halted_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  assign sw         = sw_q;
  assign incp       = pulse_q[0];
  assign dep        = pulse_q[1];
  assign start      = pulse_q[2];
  assign stop       = pulse_q[3];
  assign halted     = halted_q;
  assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_q2_panel_ctrl.sv
// Directed bench for q2_panel_ctrl: expected pulses go into a scoreboard queue with their
// cycle number; a negedge monitor pops and compares whenever any pulse output is high.
module tb_q2_panel_ctrl;

  localparam int LAT = 7;  // drive after edge k -> pulse visible after edge k+DEBOUNCE+3

  localparam logic [4:0] EV_INCP   = 5'b00001;
  localparam logic [4:0] EV_DEP    = 5'b00010;
  localparam logic [4:0] EV_START  = 5'b00100;
  localparam logic [4:0] EV_STOP   = 5'b01000;
  localparam logic [4:0] EV_HALTED = 5'b10000;

  typedef struct {
    int         cyc;
    logic [4:0] ev;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] sw_raw;
  logic        incp_raw, dep_raw, start_raw, stop_raw, run;
  logic [11:0] sw;
  logic        incp, dep, start, stop, halted;
  logic [3:0]  run_cycles;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t exp_q[$];

  q2_panel_ctrl #(
    .WIDTH(12), .DEBOUNCE(4), .REPEAT_DELAY(20), .REPEAT_RATE(8), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst), .sw_raw(sw_raw),
    .incp_raw(incp_raw), .dep_raw(dep_raw), .start_raw(start_raw), .stop_raw(stop_raw),
    .run(run), .sw(sw), .incp(incp), .dep(dep), .start(start), .stop(stop),
    .halted(halted), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_ev(input int c, input logic [4:0] ev);
    exp_t e;
    e.cyc = c;
    e.ev  = ev;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sample_at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  // Monitor: any pulse output must match the oldest scoreboard entry in cycle and kind.
  always @(negedge clk) begin
    logic [4:0] ev_now;
    exp_t       e;
    ev_now = {halted, stop, start, dep, incp};
    if (!rst && (|ev_now)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(ev_now), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", 32'(ev_now), 32'(e.ev));
        check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int k;
    rst = 1'b1; sw_raw = '0; run = 1'b0;
    incp_raw = 1'b0; dep_raw = 1'b0; start_raw = 1'b0; stop_raw = 1'b1;

    // Reset with stop held through it.
    step(3);
    @(negedge clk);
    check("reset_sw", 32'(sw), 32'd0);
    check("reset_run_cycles", 32'(run_cycles), 32'd0);
    check("reset_pulses", 32'({halted, stop, start, dep, incp}), 32'd0);
    step(1);
    rst = 1'b0;
    step(15);
    stop_raw = 1'b0;
    step(12);
    k = cyc; stop_raw = 1'b1; expect_ev(k + LAT, EV_STOP);
    step(8);
    stop_raw = 1'b0;
    step(12);

    // Plain start press with run low, then a short dep glitch.
    k = cyc; start_raw = 1'b1; expect_ev(k + LAT, EV_START);
    sample_at(k + LAT + 1);
    check("run_cycles_after_start", 32'(run_cycles), 32'd0);
    step(2);
    start_raw = 1'b0;
    step(12);
    dep_raw = 1'b1;
    step(2);
    dep_raw = 1'b0;
    step(10);

    // Switch bus: accept after DEBOUNCE+2 edges, ignore a 3-cycle glitch, then a real change.
    k = cyc; sw_raw = 12'h5A3;
    sample_at(k + 6);
    check("sw_before_accept", 32'(sw), 32'd0);
    sample_at(k + 7);
    check("sw_accept", 32'(sw), 32'h5A3);
    step(3);
    sw_raw = 12'h000;
    step(3);
    sw_raw = 12'h5A3;
    step(12);
    @(negedge clk);
    check("sw_glitch_ignored", 32'(sw), 32'h5A3);
    step(1);
    sw_raw = 12'h0A5;
    step(10);
    @(negedge clk);
    check("sw_change", 32'(sw), 32'h0A5);
    step(1);

    // Lockout while running: only stop gets through; halted follows run falling.
    k = cyc; run = 1'b1;
    incp_raw = 1'b1; dep_raw = 1'b1; start_raw = 1'b1;
    step(2);
    stop_raw = 1'b1; expect_ev(k + 2 + LAT, EV_STOP);
    step(8);
    incp_raw = 1'b0; dep_raw = 1'b0; start_raw = 1'b0; stop_raw = 1'b0;
    step(2);
    run = 1'b0; expect_ev(k + 14, EV_HALTED);
    sample_at(k + 13);
    check("run_cycles_count", 32'(run_cycles), 32'd12);
    step(12);

    // Simultaneous start and stop: stop wins, start is dropped for good.
    k = cyc; start_raw = 1'b1; stop_raw = 1'b1; expect_ev(k + LAT, EV_STOP);
    step(15);
    start_raw = 1'b0; stop_raw = 1'b0;
    step(12);

    // Auto-repeat: hold incp for 60 cycles.
    k = cyc; incp_raw = 1'b1;
    expect_ev(k + LAT, EV_INCP);
    for (int i = 0; i < 5; i++) expect_ev(k + LAT + 20 + 8 * i, EV_INCP);
    step(60);
    incp_raw = 1'b0;
    step(15);

    // Saturation of the 4-bit run counter, then clear on a start pulse.
    k = cyc; run = 1'b1;
    step(20);
    run = 1'b0; expect_ev(k + 22, EV_HALTED);
    sample_at(k + 21);
    check("run_cycles_saturate", 32'(run_cycles), 32'd15);
    step(5);
    k = cyc; start_raw = 1'b1; expect_ev(k + LAT, EV_START);
    sample_at(k + LAT - 1);
    check("run_cycles_before_clear", 32'(run_cycles), 32'd15);
    sample_at(k + LAT);
    check("run_cycles_cleared", 32'(run_cycles), 32'd0);
    step(3);
    start_raw = 1'b0;
    step(12);

    // Reset mid-debounce with dep held: no pulse until released and pressed again.
    dep_raw = 1'b1;
    step(3);
    rst = 1'b1;
    step(2);
    @(negedge clk);
    check("reset_clears_sw", 32'(sw), 32'd0);
    step(1);
    rst = 1'b0;
    step(20);
    dep_raw = 1'b0;
    step(12);
    k = cyc; dep_raw = 1'b1; expect_ev(k + LAT, EV_DEP);
    step(10);
    dep_raw = 1'b0;
    step(12);

    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/q2_panel_ctrl.md
# q2_panel_ctrl

Synthesizable front-panel controller for the q2 12-bit machine. Conditions raw switch/button inputs (synchronize, debounce) and turns button presses into single-cycle command pulses (incp, dep, start, stop) for the CPU core. Generalises the panel stimulus path with parametrised width and debounce depth, run-time lockout, command priority, incp auto-repeat, and a run-cycle monitor with halt detection. Sits between board I/O and the q2 core.

## Interface
- WIDTH, 12: data switch bus width.
- DEBOUNCE, 16: consecutive stable cycles required to accept a new level (≥1).
- REPEAT_DELAY, 0: cycles incp must stay held before auto-repeat starts; 0 disables auto-repeat.
- REPEAT_RATE, 1024: cycles between auto-repeat pulses (≥1).
- CNT_WIDTH, 32: run-cycle counter width.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sw_raw  in  WIDTH  raw data switches (asynchronous).
- incp_raw, dep_raw, start_raw, stop_raw  in  1 each  raw buttons (asynchronous, high = pressed).
- run  in  1  core run status.
- sw  out  WIDTH  debounced data switches.
- incp, dep, start, stop  out  1 each  one-cycle command pulses.
- halted  out  1  one-cycle pulse on run falling 1→0.
- run_cycles  out  CNT_WIDTH  cycles spent with run=1 since last start pulse.

## Operation
- Every raw input passes a 2-flop synchronizer before any other logic.
- Buttons: per-button stable state plus counter. Counter increments while the synchronized level differs from the stable state and clears to 0 whenever they agree; when it reaches DEBOUNCE the stable state takes the new level and the counter clears.
- Switch bus: one shared counter; synchronized bus must hold one unchanged value ≠ sw for DEBOUNCE consecutive cycles, then sw loads it. Any change mid-count restarts the count.
- Edge → pulse: a stable-state 0→1 transition raises a candidate for that button; released (1→0) produces nothing.
- Arming: after reset each button is disarmed; it arms only once its stable state has been 0. A button held through reset produces no pulse until released and pressed again.
- Lockout: while run=1, incp/dep/start candidates are discarded; stop is always accepted.
- Priority: if several candidates arise in one cycle, only the highest is issued: stop > start > dep > incp. Dropped candidates are not queued.
- Auto-repeat (REPEAT_DELAY>0): while incp stable state=1 and run=0, a cycle counter runs from the initial incp pulse; extra incp pulse at REPEAT_DELAY, then every REPEAT_RATE cycles. Release, run=1, or any higher-priority pulse stops and clears the repeat counter. Repeat pulses obey the same priority rules.
- Run monitor: run registered once internally (run_q). halted = run_q & ~run-registered transition, i.e. pulses one cycle after run is seen falling. run_cycles increments each cycle run=1, saturates at all-ones, clears to 0 on every issued start pulse (the clear wins over increment in that cycle).

## Timing
- Reset values: sw=0, incp=dep=start=stop=halted=0, run_cycles=0; all stable states, counters, synchronizers 0; buttons disarmed.
- Reset asserted mid-debounce or mid-repeat aborts it; no pulse is issued in the reset cycle or the first cycle after.
- Button latency: raw level sampled at edge N and held → command pulse asserted in the cycle following edge N+DEBOUNCE+2 (2 sync + DEBOUNCE count + 1 output register); exactly one cycle wide.
- Switch latency: sw updates DEBOUNCE+2 edges after the first sampling edge of the new value.
- Glitch shorter than DEBOUNCE synchronized cycles: no state change, no pulse.
- Lockout and priority are evaluated in the output-register cycle, against run at that edge.
- halted latency: 2 cycles from run falling at the core output.
- Minimum press-to-press spacing for distinct pulses: 2·DEBOUNCE+ cycles (press accepted, release accepted).

## Test plan
- DEBOUNCE=4: hold start_raw high from cycle 10 with run=0 → start pulse exactly one cycle at cycle 17; run_cycles=0; 2-cycle glitch on dep_raw → no dep pulse.
- sw_raw=0x5A3 stable → sw=0x5A3 after 6 edges; toggle to 0x000 for 3 cycles then back → sw stays 0x5A3.
- run=1, press incp, dep, start → no pulses; press stop → stop pulse; drop run → halted pulse 2 cycles later, run_cycles equals cycles run was high.
- start_raw and stop_raw rise same cycle, run=0 → only stop pulses; start never issued afterward without a new press.
- REPEAT_DELAY=20, REPEAT_RATE=8, hold incp 60 cycles → pulses at T, T+20, T+28, T+36, T+44, T+52 (within hold window); release → no more.
- stop_raw held high across rst → no stop pulse; release then press → one stop pulse; CNT_WIDTH=4 with run held 20 cycles → run_cycles saturates at 15.
